// File: rtl/data_bus_pkg.sv
// data_bus shared constants: peripheral address map and UART state encoding.
// Imported by the bus top and the UART transmitter.
package data_bus_pkg;

  localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR       = 32'h8000_0000;
  localparam logic [31:0] TIMER_ADDR     = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
  localparam logic [31:0] UART_STAT_ADDR = 32'h8000_000C;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Word-granular register match; byte offset bits are ignored.
  function automatic logic reg_hit(
    input logic [31:0] a,
    input logic [31:0] r
  );
    return a[31:2] == r[31:2];
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter.
// Accepts a byte only while idle; txd is registered and idles high.
module uart_tx
  import data_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_MAX);
  assign busy     = (state_q != UART_IDLE);
  assign txd      = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    baud_d  = (state_q == UART_IDLE || baud_end) ? '0 : baud_q + 1'b1;
    unique case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          sh_d    = data;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      UART_START: begin
        if (baud_end) begin
          state_d = UART_DATA;
          txd_d   = sh_q[0];
        end
      end
      UART_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            txd_d   = 1'b1;
          end else begin
            // sh_q[0] is on the line; present the next bit
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
      UART_STOP: begin
        if (baud_end) state_d = UART_IDLE;
      end
      default: state_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/data_bus.sv
// CPU data bus: word RAM, LED register, free-running timer and UART TX.
// Read data is registered; RAM is read-first.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_we,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic [15:0] led,
  output logic        uart_txd
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] idx;
  logic          ram_hit, sel_led, sel_tmr, sel_tx, sel_sts;
  logic          uart_busy, uart_start;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   timer_q, timer_d;
  logic [15:0]   led_q, led_d;
  logic          unused_addr;

  assign unused_addr = ^ram_addr[1:0];
  assign idx     = ram_addr[AW+1:2];
  assign ram_hit = (ram_addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign sel_led = reg_hit(ram_addr, LED_ADDR);
  assign sel_tmr = reg_hit(ram_addr, TIMER_ADDR);
  assign sel_tx  = reg_hit(ram_addr, UART_TX_ADDR);
  assign sel_sts = reg_hit(ram_addr, UART_STAT_ADDR);

  assign uart_start = ram_we && sel_tx && !rst;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we && ram_hit && !rst) mem[idx] <= ram_wdata;
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      ram_hit: rdata_d = mem[idx];
      sel_led: rdata_d = {16'h0000, led_q};
      sel_tmr: rdata_d = timer_q;
      sel_sts: rdata_d = {31'd0, uart_busy};
      default: rdata_d = '0;
    endcase
  end

  always_comb begin
    timer_d = (ram_we && sel_tmr) ? '0 : timer_q + 32'd1;
    led_d   = (ram_we && sel_led) ? ram_wdata[15:0] : led_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      timer_q <= '0;
      led_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  assign ram_rdata = rdata_q;
  assign led       = led_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start),
    .data (ram_wdata[7:0]),
    .busy (uart_busy),
    .txd  (uart_txd)
  );

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus with a read-data scoreboard queue.
// Small RAM and a 4-cycle bit period keep the run short.
module tb_data_bus;
  import data_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_we = 1'b0;
  logic [31:0] ram_addr = '0;
  logic [31:0] ram_wdata = '0;
  logic [31:0] ram_rdata;
  logic [15:0] led;
  logic        uart_txd;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned mark = 0;
  logic [31:0] exp_q[$];
  logic [31:0] te;

  data_bus #(
    .RAM_WORDS   (64),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .led      (led),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(input logic we, input logic [31:0] a,
                      input logic [31:0] d, input bit chk,
                      input logic [31:0] exp, input string tag);
    ram_we    = we;
    ram_addr  = a;
    ram_wdata = d;
    if (chk) exp_q.push_back(exp);
    tick();
    ram_we = 1'b0;
    if (chk) check(tag, ram_rdata, exp_q.pop_front());
  endtask

  function automatic logic exp_txd(input logic [7:0] dat, input int i);
    int b;
    b = i / 4;
    if (i >= 40) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return dat[b-1];
  endfunction

  initial begin
    tick();
    tick();
    check("rst_rdata", ram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_busy", {31'd0, dut.u_uart.busy}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++)
      xfer(1'b0, TIMER_ADDR, '0, 1'b1, 32'(k), "timer_run");
    xfer(1'b1, TIMER_ADDR, 32'h1234, 1'b0, '0, "");
    xfer(1'b0, TIMER_ADDR, '0, 1'b1, 32'd0, "timer_clr0");
    xfer(1'b0, TIMER_ADDR, '0, 1'b1, 32'd1, "timer_clr1");
    force dut.timer_q = 32'hFFFF_FFFF;
    #1;
    release dut.timer_q;
    xfer(1'b0, TIMER_ADDR, '0, 1'b1, 32'hFFFF_FFFF, "timer_max");
    xfer(1'b0, TIMER_ADDR, '0, 1'b1, 32'h0, "timer_wrap");
    mark = cyc;

    xfer(1'b1, 32'h0, 32'h5A5A_0000, 1'b0, '0, "");
    xfer(1'b1, 32'h14, 32'h1111_1111, 1'b0, '0, "");
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, "");
    xfer(1'b0, 32'h10, '0, 1'b1, 32'hDEAD_BEEF, "ram_rd10");
    xfer(1'b0, 32'h14, '0, 1'b1, 32'h1111_1111, "ram_rd14");
    xfer(1'b1, 32'h10, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, "ram_rdfirst");
    xfer(1'b0, 32'h10, '0, 1'b1, 32'hCAFE_F00D, "ram_new");
    xfer(1'b0, 32'h13, '0, 1'b1, 32'hCAFE_F00D, "ram_byteoff");

    xfer(1'b1, LED_ADDR, 32'h1234_A5A5, 1'b0, '0, "");
    check("led_out", {16'h0, led}, 32'h0000_A5A5);
    xfer(1'b0, LED_ADDR, '0, 1'b1, 32'h0000_A5A5, "led_rd");

    xfer(1'b1, 32'h4000_0000, 32'h77, 1'b1, 32'h0, "unm_wr");
    xfer(1'b0, 32'h4000_0000, '0, 1'b1, 32'h0, "unm_rd");
    check("unm_led", {16'h0, led}, 32'h0000_A5A5);
    xfer(1'b0, 32'h0, '0, 1'b1, 32'h5A5A_0000, "unm_ram0");
    te = 32'(cyc - mark + 1);
    xfer(1'b0, TIMER_ADDR, '0, 1'b1, te, "unm_timer");

    // Frame of 0x55; 0xFF written mid-frame must be dropped
    xfer(1'b1, UART_TX_ADDR, 32'h55, 1'b1, 32'h0, "uart_txrd");
    for (int i = 0; i < 45; i++) begin
      check($sformatf("uart_txd[%0d]", i), {31'd0, uart_txd},
            {31'd0, exp_txd(8'h55, i)});
      if (i == 10)
        xfer(1'b1, UART_TX_ADDR, 32'hFF, 1'b1, 32'h0, "uart_drop");
      else
        xfer(1'b0, UART_STAT_ADDR, '0, 1'b1, {31'd0, i < 40},
             $sformatf("uart_busy[%0d]", i));
    end

    xfer(1'b1, UART_TX_ADDR, 32'hA5, 1'b1, 32'h0, "uart2_txrd");
    for (int i = 0; i < 17; i++)
      xfer(1'b0, UART_STAT_ADDR, '0, 1'b0, '0, "");
    check("uart2_bit3", {31'd0, uart_txd}, {31'd0, exp_txd(8'hA5, 17)});
    rst = 1'b1;
    xfer(1'b1, 32'h10, 32'h0, 1'b1, 32'h0, "rst_mid_rdata");
    check("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_mid_busy", {31'd0, dut.u_uart.busy}, 32'd0);
    check("rst_mid_led", {16'h0, led}, 32'h0);
    rst = 1'b0;
    xfer(1'b1, UART_TX_ADDR, 32'h3C, 1'b1, 32'h0, "post_rst_wr");
    check("post_rst_txd", {31'd0, uart_txd}, 32'd0);
    check("post_rst_busy", {31'd0, dut.u_uart.busy}, 32'd1);
    xfer(1'b0, 32'h10, '0, 1'b1, 32'hCAFE_F00D, "ram_keep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
